// File: rtl/dadda_pkg.sv
// rtl/dadda_pkg.sv - shared types and widths for the dadda multiply-accumulate path
package dadda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DADDA_OPND_W = 8;
  localparam int DADDA_PROD_W = 2 * DADDA_OPND_W;
  localparam int DADDA_ACC_W  = 24;

endpackage

// File: rtl/dadda_mac_accumulator_if.sv
// rtl/dadda_mac_accumulator_if.sv - product stream in, result stream out
interface dadda_mac_accumulator_if
  import dadda_pkg::*;
#(
  parameter int PROD_W = DADDA_PROD_W,
  parameter int ACC_W  = DADDA_ACC_W
);
  logic              prod_valid_i;
  logic [PROD_W-1:0] prod_i;
  logic              prod_ready_o;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [ACC_W-1:0]  res_o;

  modport master (
    output prod_valid_i, prod_i, res_ready_i,
    input  prod_ready_o, res_valid_o, res_o
  );

  modport slave (
    input  prod_valid_i, prod_i, res_ready_i,
    output prod_ready_o, res_valid_o, res_o
  );
endinterface

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - unsigned add with carry-out and optional clamp to all-ones
module sat_adder #(
  parameter int W        = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);
  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];
  assign sum   = (carry && SATURATE) ? {W{1'b1}} : full[W-1:0];
endmodule

// File: rtl/dadda_mac_accumulator.sv
// rtl/dadda_mac_accumulator.sv - accumulates a programmed number of products
// into a wide sum and hands it off over a valid/ready handshake.
module dadda_mac_accumulator
  import dadda_pkg::*;
#(
  parameter int PROD_W   = DADDA_PROD_W,
  parameter int LEN_W    = 8,
  parameter int ACC_W    = DADDA_ACC_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  dadda_mac_accumulator_if.slave bus,
  output logic             ovf_o,
  output logic             busy_o,
  output logic [LEN_W-1:0] cnt_o
);
  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] target;
  logic [LEN_W-1:0] cnt_inc;
  logic             ovf;
  logic             busy;
  logic             res_valid;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             take;
  logic             launch;

  sat_adder #(
    .W        (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a     (acc),
    .b     ({{(ACC_W-PROD_W){1'b0}}, bus.prod_i}),
    .sum   (sum),
    .carry (carry)
  );

  assign cnt_inc = cnt + LEN_W'(1);
  assign take    = (state == ACCUM) && bus.prod_valid_i && !abort_i;
  // A new run may begin from IDLE or in the very cycle the result is taken.
  assign launch  = start_i && !abort_i &&
                   ((state == IDLE) || ((state == DONE) && bus.res_ready_i));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      acc       <= '0;
      res       <= '0;
      cnt       <= '0;
      target    <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else if (abort_i) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            acc <= sum;
            cnt <= cnt_inc;
            if (carry) ovf <= 1'b1;
            if (cnt_inc == target) begin
              state     <= DONE;
              res       <= sum;
              res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready_i) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase

      // Placed last so a back-to-back start overrides the DONE->IDLE exit.
      if (launch) begin
        acc  <= '0;
        cnt  <= '0;
        ovf  <= 1'b0;
        busy <= 1'b1;
        if (len_i == '0) begin
          state     <= DONE;
          res       <= '0;
          res_valid <= 1'b1;
        end else begin
          state     <= ACCUM;
          target    <= len_i;
          res_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.prod_ready_o = (state == ACCUM) && !abort_i;
  assign bus.res_valid_o  = res_valid;
  assign bus.res_o        = res;
  assign ovf_o            = ovf;
  assign busy_o           = busy;
  assign cnt_o            = cnt;
endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// tb/tb_dadda_mac_accumulator.sv - directed-vector bench for dadda_mac_accumulator
module tb_dadda_mac_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [7:0] len;
  logic       o_start;
  logic [7:0] o_len;

  logic       m_ovf, m_busy;
  logic [7:0] m_cnt;
  logic       s_ovf, s_busy, w_ovf, w_busy;
  logic [7:0] s_cnt, w_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dadda_mac_accumulator_if #(.PROD_W(16), .ACC_W(24)) mif ();
  dadda_mac_accumulator_if #(.PROD_W(16), .ACC_W(17)) sif ();
  dadda_mac_accumulator_if #(.PROD_W(16), .ACC_W(17)) wif ();

  dadda_mac_accumulator #(.PROD_W(16), .LEN_W(8), .ACC_W(24), .SATURATE(1'b1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .len_i(len), .abort_i(abort),
    .bus(mif), .ovf_o(m_ovf), .busy_o(m_busy), .cnt_o(m_cnt)
  );

  dadda_mac_accumulator #(.PROD_W(16), .LEN_W(8), .ACC_W(17), .SATURATE(1'b1)) dut_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(o_start), .len_i(o_len), .abort_i(1'b0),
    .bus(sif), .ovf_o(s_ovf), .busy_o(s_busy), .cnt_o(s_cnt)
  );

  dadda_mac_accumulator #(.PROD_W(16), .LEN_W(8), .ACC_W(17), .SATURATE(1'b0)) dut_wrap (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(o_start), .len_i(o_len), .abort_i(1'b0),
    .bus(wif), .ovf_o(w_ovf), .busy_o(w_busy), .cnt_o(w_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; len = 8'd0;
    o_start = 1'b0; o_len = 8'd0;
    mif.prod_valid_i = 1'b0; mif.prod_i = '0; mif.res_ready_i = 1'b0;
    sif.prod_valid_i = 1'b0; sif.prod_i = '0; sif.res_ready_i = 1'b0;
    wif.prod_valid_i = 1'b0; wif.prod_i = '0; wif.res_ready_i = 1'b0;
    cyc(3);
    check("rst_res_valid", mif.res_valid_o, 0);
    check("rst_prod_ready", mif.prod_ready_o, 0);
    check("rst_busy", m_busy, 0);
    check("rst_cnt", m_cnt, 0);
    check("rst_res", mif.res_o, 0);
    check("rst_ovf", m_ovf, 0);
    rst = 1'b0;

    // basic run: 4 x 0xFE01
    cyc(1);
    start = 1'b1; len = 8'd4;
    cyc(1);
    start = 1'b0;
    check("t1_busy", m_busy, 1);
    check("t1_prod_ready", mif.prod_ready_o, 1);
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'hFE01;
    cyc(3);
    check("t1_cnt3", m_cnt, 3);
    check("t1_no_valid_yet", mif.res_valid_o, 0);
    cyc(1);
    mif.prod_valid_i = 1'b0;
    check("t1_res_valid", mif.res_valid_o, 1);
    check("t1_res", mif.res_o, 32'h03F804);
    check("t1_ovf", m_ovf, 0);
    check("t1_cnt4", m_cnt, 4);
    check("t1_prod_ready_done", mif.prod_ready_o, 0);
    mif.res_ready_i = 1'b1;
    cyc(1);
    mif.res_ready_i = 1'b0;
    check("t1_after_hs_valid", mif.res_valid_o, 0);
    check("t1_after_hs_busy", m_busy, 0);
    check("t1_res_kept", mif.res_o, 32'h03F804);

    // overflow: 17-bit accumulators, 3 x 0xFFFF
    o_start = 1'b1; o_len = 8'd3;
    cyc(1);
    o_start = 1'b0;
    sif.prod_valid_i = 1'b1; sif.prod_i = 16'hFFFF;
    wif.prod_valid_i = 1'b1; wif.prod_i = 16'hFFFF;
    cyc(3);
    sif.prod_valid_i = 1'b0; wif.prod_valid_i = 1'b0;
    check("ovf_sat_valid", sif.res_valid_o, 1);
    check("ovf_sat_res", sif.res_o, 32'h1FFFF);
    check("ovf_sat_flag", s_ovf, 1);
    check("ovf_wrap_res", wif.res_o, 32'h0FFFD);
    check("ovf_wrap_flag", w_ovf, 1);

    // bubbles, backpressure, back-to-back restart
    start = 1'b1; len = 8'd2;
    cyc(1);
    start = 1'b0;
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd3;
    cyc(1);
    mif.prod_valid_i = 1'b0;
    check("bp_cnt1", m_cnt, 1);
    cyc(1);
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd5;
    cyc(1);
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd99;
    start = 1'b1; len = 8'd3;
    check("bp_res", mif.res_o, 8);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("bp_hold_valid", mif.res_valid_o, 1);
      check("bp_hold_res", mif.res_o, 8);
      check("bp_hold_ready", mif.prod_ready_o, 0);
    end
    check("bp_hold_cnt", m_cnt, 2);
    mif.prod_valid_i = 1'b0;
    mif.res_ready_i = 1'b1; start = 1'b1; len = 8'd1;
    cyc(1);
    mif.res_ready_i = 1'b0; start = 1'b0;
    check("b2b_busy", m_busy, 1);
    check("b2b_prod_ready", mif.prod_ready_o, 1);
    check("b2b_valid_low", mif.res_valid_o, 0);
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd7;
    cyc(1);
    mif.prod_valid_i = 1'b0;
    check("b2b_res_valid", mif.res_valid_o, 1);
    check("b2b_res", mif.res_o, 7);
    mif.res_ready_i = 1'b1;
    cyc(1);
    mif.res_ready_i = 1'b0;

    // abort after 2 of 4 products
    start = 1'b1; len = 8'd4;
    cyc(1);
    start = 1'b0;
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd1;
    cyc(2);
    check("ab_cnt2", m_cnt, 2);
    abort = 1'b1;
    #1;
    check("ab_prod_ready_gated", mif.prod_ready_o, 0);
    cyc(1);
    abort = 1'b0; mif.prod_valid_i = 1'b0;
    check("ab_busy", m_busy, 0);
    check("ab_valid", mif.res_valid_o, 0);
    check("ab_cnt0", m_cnt, 0);
    check("ab_res_kept", mif.res_o, 7);

    // last product together with abort: no result
    start = 1'b1; len = 8'd1;
    cyc(1);
    start = 1'b0;
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd5; abort = 1'b1;
    cyc(1);
    mif.prod_valid_i = 1'b0; abort = 1'b0;
    check("abl_valid", mif.res_valid_o, 0);
    check("abl_busy", m_busy, 0);
    check("abl_res", mif.res_o, 7);

    // asynchronous reset mid-run
    start = 1'b1; len = 8'd4;
    cyc(1);
    start = 1'b0;
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd2;
    cyc(1);
    mif.prod_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_busy", m_busy, 0);
    check("ar_cnt", m_cnt, 0);
    check("ar_res", mif.res_o, 0);
    check("ar_prod_ready", mif.prod_ready_o, 0);
    check("ar_valid", mif.res_valid_o, 0);
    cyc(1);
    rst = 1'b0;
    start = 1'b1; len = 8'd1;
    cyc(1);
    start = 1'b0;
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd9;
    cyc(1);
    mif.prod_valid_i = 1'b0;
    check("ar_new_valid", mif.res_valid_o, 1);
    check("ar_new_res", mif.res_o, 9);
    mif.res_ready_i = 1'b1;
    cyc(1);
    mif.res_ready_i = 1'b0;

    // zero length
    start = 1'b1; len = 8'd0;
    mif.prod_valid_i = 1'b1; mif.prod_i = 16'd4;
    cyc(1);
    start = 1'b0;
    check("z_valid", mif.res_valid_o, 1);
    check("z_res", mif.res_o, 0);
    check("z_ovf", m_ovf, 0);
    check("z_cnt", m_cnt, 0);
    check("z_prod_ready", mif.prod_ready_o, 0);
    cyc(1);
    mif.prod_valid_i = 1'b0;
    check("z_cnt_still", m_cnt, 0);
    mif.res_ready_i = 1'b1;
    cyc(1);
    mif.res_ready_i = 1'b0;
    check("z_idle", m_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
